rr_grant_arbiter: RTL and testbench
===================================

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 4, meaning the grant index width.
REQ-002 SHALL have parameter IN_WIDTH, default 1<<OUT_WIDTH, meaning the requester count.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  IN_WIDTH  per-requester request level.
REQ-006 en  input  1  permits issuing a new grant this cycle.
REQ-007 release  input  1  current holder finished; frees the grant.
REQ-008 flush  input  1  drops any grant at once; no new grant this cycle.
REQ-009 gnt  output  IN_WIDTH  registered one-hot grant; all zero when idle.
REQ-010 gnt_valid  output  1  high iff gnt is non-zero.
REQ-011 gnt_idx  output  OUT_WIDTH  binary index of the set gnt bit; 0 when gnt is zero.

Function
REQ-012 SHALL implement two states, IDLE (gnt=0) and HELD (exactly one gnt bit set).
REQ-013 SHALL keep a priority pointer ptr (OUT_WIDTH bits); the winner is the first set req bit scanning ptr, ptr+1, ... IN_WIDTH-1, 0, ... ptr-1.
REQ-014 IDLE: with en=1, flush=0 and req non-zero, SHALL go to HELD with gnt = one-hot(winner) on the next edge (1-cycle latency) and set ptr = (winner+1) mod IN_WIDTH.
REQ-015 IDLE: with en=0 or req=0, SHALL stay IDLE with ptr unchanged.
REQ-016 HELD: while release=0, flush=0 and req[holder]=1, SHALL hold gnt and ptr regardless of en or other req bits.
REQ-017 HELD: release=1 or req[holder]=0 frees the grant. If en=1 and another winner exists under REQ-013 using the already-advanced ptr, the new gnt SHALL appear on the next edge with no idle bubble. Otherwise the block SHALL go to IDLE.
REQ-018 Under REQ-017, the freed holder SHALL still be eligible for re-grant if its req is high and no other requester wins first.
REQ-019 flush=1 SHALL force IDLE on the next edge, gnt=0, ptr unchanged. flush SHALL override en, release and req.
REQ-020 Wrap-around: a winner at index IN_WIDTH-1 SHALL set ptr=0.
REQ-021 gnt SHALL never have more than one bit set, and a bit SHALL only be set if that req bit was high on the granting edge.
REQ-022 gnt_valid and gnt_idx SHALL be combinational functions of the gnt register only.

Reset
REQ-023 When reset=0 at an edge: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0. Reset SHALL override all other inputs, including mid-grant.
REQ-024 The first edge with reset=1 SHALL evaluate normally; a grant is possible on that edge.

Structure
REQ-025 The default widths and the state enum (IDLE, HELD) SHALL live in the shared core package.
REQ-026 gnt_idx SHALL come from one instance of the existing priority encoder sub-module pe(gnt, enc), driven by gnt. The arbiter SHALL NOT duplicate encoder logic.
REQ-027 The rotating scan SHALL be implemented by doubling req, masking by ptr, and using a fixed-priority pick. The block SHALL contain no loops with data-dependent bounds.

Verification
REQ-028 Reset: reset=0 for 2 cycles with req=16'hffff, en=1 -> gnt=0, gnt_idx=0 on both cycles. Release reset -> gnt=16'h0001, gnt_idx=0 one cycle later.
REQ-029 Rotation: req=16'h0101, en=1, release pulsed every cycle -> gnt alternates 16'h0001, 16'h0100, 16'h0001; gnt_idx 0, 8, 0.
REQ-030 Wrap: ptr=15 (after granting 14), req=16'h8001 -> gnt=16'h8000 (idx 15); on release -> gnt=16'h0001 (idx 0), ptr=1.
REQ-031 Hold/en: grant held at idx 11 (gnt=16'h0800), en=0, req=16'h0f00, release=1 -> IDLE next cycle, gnt=0. Raise en=1 -> gnt=16'h0100 (ptr=12, scan wraps to 8).
REQ-032 Flush priority: in HELD, assert flush=1 and release=1 together with req=16'h1000, en=1 -> gnt=0 next cycle, ptr unchanged. Next cycle, flush=0 -> gnt=16'h1000, gnt_idx=12.
REQ-033 Drop: holder idx 3 (gnt=16'h0008) lowers req[3] with no release, other req=16'h0080 -> gnt=16'h0080, gnt_idx=7 next cycle. Throughout, check gnt has at most one bit set every cycle.

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: default widths and FSM state encoding.
package rr_grant_arbiter_pkg;

    localparam int OUT_WIDTH_DEF = 4;
    localparam int IN_WIDTH_DEF  = 1 << OUT_WIDTH_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_grant_arbiter_pe.sv
// Priority encoder: binary index of the lowest set bit, zero when no bit is set.
module rr_grant_arbiter_pe
    import rr_grant_arbiter_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic [IN_WIDTH-1:0]  i_gnt,
    output logic [OUT_WIDTH-1:0] o_enc
);

    // NOTE: the default assignment ahead of the loop keeps this purely combinational (no latch).
    always_comb begin
        o_enc = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (i_gnt[i]) o_enc = OUT_WIDTH'(i);
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until release, drop or flush.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IN_WIDTH  = 1 << OUT_WIDTH
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [IN_WIDTH-1:0]  i_req,
    input  logic                 i_en,
    input  logic                 i_release,
    input  logic                 i_flush,
    output logic [IN_WIDTH-1:0]  o_gnt,
    output logic                 o_gnt_valid,
    output logic [OUT_WIDTH-1:0] o_gnt_idx
);

    localparam int DBL_WIDTH = 2 * IN_WIDTH;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IN_WIDTH-1:0]  r_gnt;
    logic [IN_WIDTH-1:0]  w_gnt_nxt;
    logic [OUT_WIDTH-1:0] r_ptr;
    logic [OUT_WIDTH-1:0] w_ptr;
    logic [OUT_WIDTH-1:0] w_idx;
    logic [DBL_WIDTH-1:0] w_dbl_req;
    logic [DBL_WIDTH-1:0] w_masked;
    logic [DBL_WIDTH-1:0] w_pick;
    logic [IN_WIDTH-1:0]  w_winner;
    logic                 w_has_winner;
    logic                 w_keep;

    rr_grant_arbiter_pe #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_pe (
        .i_gnt (r_gnt),
        .o_enc (w_idx)
    );

    assign o_gnt       = r_gnt;
    assign o_gnt_valid = |r_gnt;
    assign o_gnt_idx   = w_idx;

    // While a grant is held the pointer is holder+1, derived from the encoder; r_ptr
    // only carries that value across idle periods, so no second encoder is needed.
    assign w_ptr = (r_state == HELD)
                 ? ((w_idx == OUT_WIDTH'(IN_WIDTH - 1)) ? '0 : w_idx + OUT_WIDTH'(1))
                 : r_ptr;

    assign w_dbl_req    = {i_req, i_req};
    assign w_masked     = w_dbl_req & ({DBL_WIDTH{1'b1}} << w_ptr);
    assign w_pick       = w_masked & (~w_masked + DBL_WIDTH'(1));
    assign w_winner     = w_pick[IN_WIDTH-1:0] | w_pick[DBL_WIDTH-1:IN_WIDTH];
    assign w_has_winner = |w_masked;
    assign w_keep       = ~i_release & (|(i_req & r_gnt));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_en && w_has_winner) begin
                        w_state_nxt = HELD;
                        w_gnt_nxt   = w_winner;
                    end
                end
                HELD: begin
                    if (!w_keep) begin
                        if (i_en && w_has_winner) begin
                            w_gnt_nxt = w_winner;
                        end else begin
                            w_state_nxt = IDLE;
                            w_gnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed vectors push expected grants, a monitor compares.
module tb_rr_grant_arbiter;

    localparam int OW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] req;
    logic          en;
    logic          rel;
    logic          flush;
    logic [IW-1:0] gnt;
    logic          gnt_valid;
    logic [OW-1:0] gnt_idx;

    typedef struct {
        logic [IW-1:0] gnt;
        logic [OW-1:0] idx;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    rr_grant_arbiter #(
        .OUT_WIDTH (OW),
        .IN_WIDTH  (IW)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_req       (req),
        .i_en        (en),
        .i_release   (rel),
        .i_flush     (flush),
        .o_gnt       (gnt),
        .o_gnt_valid (gnt_valid),
        .o_gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs and queue the grant expected after the following edge.
    task automatic step(input string nm, input logic r, input logic [IW-1:0] rq, input logic e,
                        input logic rl, input logic f, input logic [IW-1:0] eg,
                        input logic [OW-1:0] ei);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        en    = e;
        rel   = rl;
        flush = f;
        x.gnt  = eg;
        x.idx  = ei;
        x.name = nm;
        sb_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, "_gnt"}, 32'(gnt), 32'(e.gnt));
                check({e.name, "_idx"}, 32'(gnt_idx), 32'(e.idx));
                check({e.name, "_valid"}, 32'(gnt_valid), 32'(|e.gnt));
                check({e.name, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
            end
        end
    end

    initial begin : stimulus
        bit drained;
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        rel   = 1'b0;
        flush = 1'b0;

        //    name          rst   req       en    rel   flush  exp_gnt   exp_idx
        step("reset0",     1'b0, 16'hffff, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("reset1",     1'b0, 16'hffff, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("rst_rel",    1'b1, 16'hffff, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd0);
        step("rot_a",      1'b1, 16'h0101, 1'b1, 1'b1, 1'b0, 16'h0100, 4'd8);
        step("rot_b",      1'b1, 16'h0101, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd0);
        step("rot_c",      1'b1, 16'h0101, 1'b1, 1'b1, 1'b0, 16'h0100, 4'd8);
        step("rot_d",      1'b1, 16'h0101, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd0);
        step("hold_a",     1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd0);
        step("hold_b",     1'b1, 16'hffff, 1'b0, 1'b0, 1'b0, 16'h0001, 4'd0);
        step("to14",       1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h4000, 4'd14);
        step("wrap_15",    1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 16'h8000, 4'd15);
        step("wrap_0",     1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd0);
        step("to11",       1'b1, 16'h0800, 1'b1, 1'b1, 1'b0, 16'h0800, 4'd11);
        step("en_off",     1'b1, 16'h0f00, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0);
        step("idle_stay",  1'b1, 16'h0f00, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("en_on",      1'b1, 16'h0f00, 1'b1, 1'b0, 1'b0, 16'h0100, 4'd8);
        step("flush",      1'b1, 16'h1000, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd0);
        step("post_flush", 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 16'h1000, 4'd12);
        step("to3",        1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 16'h0008, 4'd3);
        step("drop",       1'b1, 16'h0080, 1'b1, 1'b0, 1'b0, 16'h0080, 4'd7);
        step("regrant",    1'b1, 16'h0080, 1'b1, 1'b1, 1'b0, 16'h0080, 4'd7);
        step("mid_rst",    1'b0, 16'hffff, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("rst_ptr",    1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd0);
        step("req0_a",     1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("req0_b",     1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0);
        step("idle_flush", 1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0);
        step("after_fl",   1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004, 4'd2);

        drained = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", 32'(drained), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
